// File: rtl/spram_arbiter_pkg.sv
// spram_arb_pkg: shared types and constants for the single-port RAM arbiter.
//   arb_state_t : ownership state (IDLE, OWN_A, OWN_B)
//   PORT_A/B    : port identifiers used for the last-grant register
//   BCNT_W      : width of the burst counter (covers MAX_BURST up to 15)
package spram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam int   BCNT_W = 4;

endpackage

// File: rtl/spram_arbiter_if.sv
// spram_arbiter_if: requester-side bus for both arbiter ports.
//   a_* : instruction-fetch port, b_* : data/vector port
//   master modport = requesters, slave modport = arbiter
interface spram_arbiter_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) ();
  logic              a_en, b_en;
  logic              a_we, b_we;
  logic [AWIDTH-1:0] a_address, b_address;
  logic [DWIDTH/8-1:0] a_byteen, b_byteen;
  logic [DWIDTH-1:0] a_writedata, b_writedata;
  logic              a_wait, b_wait;
  logic [DWIDTH-1:0] a_readdata, b_readdata;
  logic              a_rvalid, b_rvalid;

  modport master (
    output a_en, b_en, a_we, b_we, a_address, b_address,
           a_byteen, b_byteen, a_writedata, b_writedata,
    input  a_wait, b_wait, a_readdata, b_readdata, a_rvalid, b_rvalid
  );

  modport slave (
    input  a_en, b_en, a_we, b_we, a_address, b_address,
           a_byteen, b_byteen, a_writedata, b_writedata,
    output a_wait, b_wait, a_readdata, b_readdata, a_rvalid, b_rvalid
  );
endinterface

// File: rtl/spram_arbiter_sel.sv
// spram_arb_sel: purely combinational grant selector.
//   a_req/b_req : qualified requests
//   state, burst_cnt, last_gnt : arbiter history from the top
//   gnt_a/gnt_b : one-hot (or zero) grant for this cycle
module spram_arb_sel
  import spram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              a_req,
  input  logic              b_req,
  input  arb_state_t        state,
  input  logic [BCNT_W-1:0] burst_cnt,
  input  logic              last_gnt,
  output logic              gnt_a,
  output logic              gnt_b
);
  localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BURST);

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (a_req && !b_req) begin
      gnt_a = 1'b1;
    end else if (b_req && !a_req) begin
      gnt_b = 1'b1;
    end else if (a_req && b_req) begin
      case (state)
        OWN_A: if (burst_cnt < MAX_B) gnt_a = 1'b1; else gnt_b = 1'b1;
        OWN_B: if (burst_cnt < MAX_B) gnt_b = 1'b1; else gnt_a = 1'b1;
        // from IDLE, the port that was not served last goes first
        default: if (last_gnt == PORT_B) gnt_a = 1'b1; else gnt_b = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-port byte-enabled RAM between two requesters.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : requester ports A and B (spram_arbiter_if.slave)
//   ram_*       : RAM address/wren/byteen/data, ram_out = registered read data
// Optional build macro SPRAM_ARB_STATS_EN adds a_stall_cnt/b_stall_cnt,
// saturating counts of cycles each port spent stalled.
//
// state | meaning
// IDLE  | no owner, no grant last cycle
// OWN_A | port A granted last cycle
// OWN_B | port B granted last cycle
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int AWIDTH    = 10,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                resetn,
  spram_arbiter_if.slave      bus,
  output logic [AWIDTH-1:0]   ram_address,
  output logic                ram_wren,
  output logic [DWIDTH/8-1:0] ram_byteen,
  output logic [DWIDTH-1:0]   ram_data,
  input  logic [DWIDTH-1:0]   ram_out
`ifdef SPRAM_ARB_STATS_EN
  ,
  output logic [31:0]         a_stall_cnt,
  output logic [31:0]         b_stall_cnt
`endif
);
  localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BURST);

  arb_state_t        state, state_nxt;
  logic [BCNT_W-1:0] burst_cnt, burst_nxt;
  logic              last_gnt, last_nxt;
  logic              a_req, b_req, gnt_a, gnt_b, gnt, g_we;
  logic [AWIDTH-1:0] g_addr, addr_q;
  logic [DWIDTH-1:0] g_wd, data_q;
  logic [DWIDTH/8-1:0] g_be;
  logic              rv_a, rv_b;

  // nothing is granted while reset is held
  assign a_req = bus.a_en & resetn;
  assign b_req = bus.b_en & resetn;

  spram_arb_sel #(.MAX_BURST(MAX_BURST)) u_sel (
    .a_req(a_req), .b_req(b_req), .state(state), .burst_cnt(burst_cnt),
    .last_gnt(last_gnt), .gnt_a(gnt_a), .gnt_b(gnt_b)
  );

  always_comb begin
    state_nxt = IDLE;
    burst_nxt = '0;
    last_nxt  = last_gnt;
    if (gnt_a) begin
      state_nxt = OWN_A;
      last_nxt  = PORT_A;
      burst_nxt = (state != OWN_A) ? BCNT_W'(1) :
                  (burst_cnt == MAX_B) ? MAX_B : burst_cnt + 1'b1;
    end else if (gnt_b) begin
      state_nxt = OWN_B;
      last_nxt  = PORT_B;
      burst_nxt = (state != OWN_B) ? BCNT_W'(1) :
                  (burst_cnt == MAX_B) ? MAX_B : burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_gnt  <= PORT_B;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      last_gnt  <= last_nxt;
    end
  end

  assign gnt    = gnt_a | gnt_b;
  assign g_we   = gnt_b ? bus.b_we        : bus.a_we;
  assign g_addr = gnt_b ? bus.b_address   : bus.a_address;
  assign g_be   = gnt_b ? bus.b_byteen    : bus.a_byteen;
  assign g_wd   = gnt_b ? bus.b_writedata : bus.a_writedata;

  // address/data hold their last values on idle cycles so the RAM sees no glitches
  assign ram_wren    = gnt & g_we;
  assign ram_byteen  = (gnt & g_we) ? g_be : '0;
  assign ram_address = gnt ? g_addr : addr_q;
  assign ram_data    = (gnt & g_we) ? g_wd : data_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q <= '0;
      data_q <= '0;
      rv_a   <= 1'b0;
      rv_b   <= 1'b0;
    end else begin
      if (gnt) addr_q <= g_addr;
      if (gnt && g_we) data_q <= g_wd;
      rv_a <= gnt_a & ~bus.a_we;
      rv_b <= gnt_b & ~bus.b_we;
    end
  end

  assign bus.a_wait     = bus.a_en & ~gnt_a;
  assign bus.b_wait     = bus.b_en & ~gnt_b;
  assign bus.a_rvalid   = rv_a;
  assign bus.b_rvalid   = rv_b;
  assign bus.a_readdata = ram_out;
  assign bus.b_readdata = ram_out;

`ifdef SPRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_stall_cnt <= '0;
      b_stall_cnt <= '0;
    end else begin
      if (bus.a_wait && (a_stall_cnt != '1)) a_stall_cnt <= a_stall_cnt + 1'b1;
      if (bus.b_wait && (b_stall_cnt != '1)) b_stall_cnt <= b_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed bench for spram_arbiter with a behavioural
// registered byte-enabled RAM. Build with SPRAM_ARB_STATS_EN to also
// exercise the stall counters.
module tb_spram_arbiter;
  logic        clk;
  logic        resetn;
  logic [9:0]  ram_address;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_data;
  logic [31:0] ram_out;
  logic [31:0] mem [0:1023];
`ifdef SPRAM_ARB_STATS_EN
  logic [31:0] a_stall_cnt, b_stall_cnt;
`endif
  int checks = 0;
  int errors = 0;

  spram_arbiter_if #(.AWIDTH(10), .DWIDTH(32)) bus ();

  spram_arbiter #(.AWIDTH(10), .DWIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_data(ram_data), .ram_out(ram_out)
`ifdef SPRAM_ARB_STATS_EN
    , .a_stall_cnt(a_stall_cnt), .b_stall_cnt(b_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) begin
      for (int i = 0; i < 4; i++)
        if (ram_byteen[i]) mem[ram_address][i*8 +: 8] <= ram_data[i*8 +: 8];
    end
    ram_out <= mem[ram_address];
  end

  task automatic idle_inputs();
    bus.a_en = 0; bus.a_we = 0; bus.a_address = '0; bus.a_byteen = '0; bus.a_writedata = '0;
    bus.b_en = 0; bus.b_we = 0; bus.b_address = '0; bus.b_byteen = '0; bus.b_writedata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 0;
    bus.a_en = 1; bus.a_we = 1; bus.a_address = 10'h007; bus.a_byteen = 4'hF; bus.a_writedata = 32'h12345678;
    #1;
    checks++; if (bus.a_wait !== 1'b1) begin errors++; $display("FAIL rst_a_wait got %0b want 1", bus.a_wait); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %0b want 0", ram_wren); end
    @(posedge clk); #1;
    checks++; if (ram_address !== 10'h000) begin errors++; $display("FAIL rst_addr got %h want 000", ram_address); end
    checks++; if (ram_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", ram_data); end
    checks++; if (ram_byteen !== 4'h0) begin errors++; $display("FAIL rst_byteen got %h want 0", ram_byteen); end
    checks++; if (bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0b%0b want 00", bus.a_rvalid, bus.b_rvalid); end
    @(negedge clk);
    idle_inputs();
    resetn = 1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.a_en = 1; bus.a_we = 0; bus.a_address = 10'h005;
    #1;
    checks++; if (bus.a_wait !== 1'b0) begin errors++; $display("FAIL rd_a_wait got %0b want 0", bus.a_wait); end
    checks++; if (ram_address !== 10'h005 || ram_wren !== 1'b0) begin errors++; $display("FAIL rd_ram_ctrl got addr %h wren %0b want 005 0", ram_address, ram_wren); end
    @(posedge clk); #1;
    bus.a_en = 0;
    checks++; if (bus.a_rvalid !== 1'b1) begin errors++; $display("FAIL rd_a_rvalid got %0b want 1", bus.a_rvalid); end
    checks++; if (bus.a_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_a_data got %h want deadbeef", bus.a_readdata); end
    checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rd_b_rvalid got %0b want 0", bus.b_rvalid); end
    @(posedge clk); #1;
    checks++; if (bus.a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_a_rvalid_drop got %0b want 0", bus.a_rvalid); end
  endtask

  task automatic test_burst();
    logic exp_a [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.a_en = 1; bus.a_we = 0; bus.a_address = 10'h001;
        bus.b_en = 1; bus.b_we = 0; bus.b_address = 10'h002;
      end
      #1;
      checks++; if (bus.a_wait !== !exp_a[i] || bus.b_wait !== exp_a[i]) begin errors++; $display("FAIL burst_wait[%0d] got a%0b b%0b want a%0b b%0b", i, bus.a_wait, bus.b_wait, !exp_a[i], exp_a[i]); end
      @(posedge clk); #1;
      checks++; if (bus.a_rvalid !== exp_a[i] || bus.b_rvalid !== !exp_a[i]) begin errors++; $display("FAIL burst_rvalid[%0d] got a%0b b%0b want a%0b b%0b", i, bus.a_rvalid, bus.b_rvalid, exp_a[i], !exp_a[i]); end
      checks++; if (bus.a_readdata !== (exp_a[i] ? 32'h0000_1111 : 32'h0000_2222)) begin errors++; $display("FAIL burst_data[%0d] got %h", i, bus.a_readdata); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    bus.b_en = 1; bus.b_we = 1; bus.b_address = 10'h010; bus.b_byteen = 4'b0101; bus.b_writedata = 32'h11223344;
    #1;
    checks++; if (bus.b_wait !== 1'b0) begin errors++; $display("FAIL wr_b_wait got %0b want 0", bus.b_wait); end
    checks++; if (ram_wren !== 1'b1 || ram_byteen !== 4'b0101 || ram_address !== 10'h010 || ram_data !== 32'h11223344) begin
      errors++; $display("FAIL wr_ram got wren %0b be %b addr %h data %h want 1 0101 010 11223344", ram_wren, ram_byteen, ram_address, ram_data); end
    @(posedge clk); #1;
    checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %0b want 0", bus.b_rvalid); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (ram_wren !== 1'b0 || ram_byteen !== 4'h0 || ram_address !== 10'h010 || ram_data !== 32'h11223344) begin
      errors++; $display("FAIL idle_hold got wren %0b be %b addr %h data %h want 0 0000 010 11223344", ram_wren, ram_byteen, ram_address, ram_data); end
    @(negedge clk);
    bus.a_en = 1; bus.a_we = 0; bus.a_address = 10'h010;
    @(posedge clk); #1;
    bus.a_en = 0;
    checks++; if (bus.a_rvalid !== 1'b1 || bus.a_readdata !== 32'hAA22CC44) begin errors++; $display("FAIL wr_readback got v%0b %h want v1 aa22cc44", bus.a_rvalid, bus.a_readdata); end
    // zero byte enables: grant is consumed but memory is untouched
    @(negedge clk);
    bus.b_en = 1; bus.b_we = 1; bus.b_address = 10'h005; bus.b_byteen = 4'b0000; bus.b_writedata = 32'hFFFFFFFF;
    #1;
    checks++; if (bus.b_wait !== 1'b0 || ram_wren !== 1'b1 || ram_byteen !== 4'h0) begin errors++; $display("FAIL be0_grant got wait %0b wren %0b be %b want 0 1 0000", bus.b_wait, ram_wren, ram_byteen); end
    @(negedge clk);
    idle_inputs();
    bus.a_en = 1; bus.a_we = 0; bus.a_address = 10'h005;
    @(posedge clk); #1;
    bus.a_en = 0;
    checks++; if (bus.a_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL be0_readback got %h want deadbeef", bus.a_readdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [4] = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i % 2 == 0) begin bus.a_en = 1; bus.a_address = 10'(i + 1); end
      else begin bus.b_en = 1; bus.b_address = 10'(i + 1); end
      @(posedge clk); #1;
      checks++; if (bus.a_rvalid !== (i % 2 == 0) || bus.b_rvalid !== (i % 2 == 1)) begin errors++; $display("FAIL b2b_rvalid[%0d] got a%0b b%0b", i, bus.a_rvalid, bus.b_rvalid); end
      checks++; if (bus.a_readdata !== exp_d[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, bus.a_readdata, exp_d[i]); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_during_read();
    @(negedge clk);
    bus.a_en = 1; bus.a_we = 0; bus.a_address = 10'h003;
    @(negedge clk);
    idle_inputs();
    bus.b_en = 1; bus.b_we = 0; bus.b_address = 10'h004;
    resetn = 0;
    #1;
    checks++; if (bus.b_wait !== 1'b1) begin errors++; $display("FAIL rstrd_b_wait got %0b want 1", bus.b_wait); end
    @(posedge clk); #1;
    checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rstrd_b_rvalid got %0b want 0", bus.b_rvalid); end
    @(negedge clk);
    resetn = 1;
    bus.a_en = 1; bus.a_address = 10'h001;
    #1;
    checks++; if (bus.a_wait !== 1'b0 || bus.b_wait !== 1'b1) begin errors++; $display("FAIL rstrd_first_gnt got a%0b b%0b want a0 b1", bus.a_wait, bus.b_wait); end
    @(posedge clk); #1;
    checks++; if (bus.a_rvalid !== 1'b1 || bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rstrd_rvalid got a%0b b%0b want a1 b0", bus.a_rvalid, bus.b_rvalid); end
    @(negedge clk);
    idle_inputs();
  endtask

`ifdef SPRAM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++; if (a_stall_cnt !== 32'd0 || b_stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_reset got %0d %0d want 0 0", a_stall_cnt, b_stall_cnt); end
    bus.a_en = 1; bus.a_address = 10'h001;
    @(negedge clk);
    bus.b_en = 1; bus.b_address = 10'h002;
    repeat (3) @(negedge clk);
    bus.a_en = 0;
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (b_stall_cnt !== 32'd3) begin errors++; $display("FAIL stats_b got %0d want 3", b_stall_cnt); end
    checks++; if (a_stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_a got %0d want 0", a_stall_cnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[1] = 32'h0000_1111; mem[2] = 32'h0000_2222; mem[3] = 32'h0000_3333; mem[4] = 32'h0000_4444;
    mem[5] = 32'hDEADBEEF; mem[16] = 32'hAABBCCDD;
    resetn = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_burst();
    test_byte_write();
    test_back_to_back();
    test_reset_during_read();
`ifdef SPRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares one single-port byte-enabled word RAM between two requesters: port A (instruction fetch) and port B (data/vector memory unit).
- Grants at most one access per cycle, registered one-cycle read return, round-robin fairness with a bounded burst length.
- Sits between the processor memory interfaces and the on-chip RAM; drives the RAM's address, wren, byteen and data inputs and consumes its registered output.

Parameters:
- AWIDTH, 10, word address width (matches RAM address port).
- DWIDTH, 32, data width; multiple of 32; byteen width DWIDTH/8.
- MAX_BURST, 4, maximum consecutive grants to one port while the other is requesting; 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- a_en, b_en  in  1  access request (held until accepted)
- a_we, b_we  in  1  1 = write, 0 = read
- a_address, b_address  in  AWIDTH  word address
- a_byteen, b_byteen  in  DWIDTH/8  byte write enables
- a_writedata, b_writedata  in  DWIDTH  write data
- a_wait, b_wait  out  1  combinational stall: en high and not granted this cycle
- a_readdata, b_readdata  out  DWIDTH  read data (both driven from ram_out)
- a_rvalid, b_rvalid  out  1  read data valid, one cycle after read grant
- ram_address  out  AWIDTH  RAM address
- ram_wren  out  1  RAM write enable
- ram_byteen  out  DWIDTH/8  RAM byte enables
- ram_data  out  DWIDTH  RAM write data
- ram_out  in  DWIDTH  RAM registered read data

Behaviour:
- Grant decision combinational from current requests, state and burst_cnt; grant = x_en & selected. Accepted access presented to the RAM in the same cycle.
- States: IDLE (no owner), OWN_A, OWN_B; registered.
- Priority: only one port requesting -> it wins. Both requesting -> current owner wins if burst_cnt < MAX_BURST, else the other port. Both requesting from IDLE -> the port not granted last (last_gnt register, reset value B so A wins first).
- Transitions: grant A -> OWN_A; grant B -> OWN_B; no request -> IDLE. burst_cnt resets to 1 on owner change or leaving IDLE; increments (saturating at MAX_BURST) on consecutive grants to the same owner; resets to 0 in IDLE.
- Ungranted cycle: ram_wren=0, ram_byteen=0; ram_address/ram_data hold previous values (no spurious writes).
- Write grant: ram_wren=1, byteen/data from the granted port; no rvalid.
- Read grant: ram_wren=0; rvalid for that port pulses exactly 1 cycle later; readdata = ram_out in that cycle. Back-to-back reads give one rvalid per cycle, in grant order.
- Byteen of 0 on a write grant is legal: no bytes change, grant still consumed.
- Requester must hold en/address/data stable while wait=1; changes during wait are taken as a new request.
- Reset (resetn=0 at clk edge): state=IDLE, burst_cnt=0, last_gnt=B, rvalid=0 on both ports, ram_wren/ram_byteen=0, ram_address=0, ram_data=0. A read granted in the cycle reset is applied produces no rvalid. No grants while resetn=0; a_wait/b_wait = en while in reset.

Optional Feature:
- SPRAM_ARB_STATS_EN: adds outputs a_stall_cnt, b_stall_cnt (32 bits each), counting cycles with wait=1 per port; saturate at all-ones; cleared by reset. Without the macro: ports and counters absent, behaviour otherwise identical.

Decomposition:
- Package spram_arb_pkg: state encoding (IDLE, OWN_A, OWN_B), port-id constants (PORT_A=0, PORT_B=1), burst counter width (4).
- Sub-module spram_arb_sel: pure grant selector (requests, state, burst_cnt, last_gnt -> gnt_a, gnt_b). Top holds registers, RAM muxing and rvalid pipeline.

Test Plan:
- Reset, then A read at address 0x005 containing 0xDEADBEEF -> a_wait=0, a_rvalid=1 next cycle with a_readdata=0xDEADBEEF; b_rvalid stays 0.
- A and B both request continuously from IDLE, MAX_BURST=4 -> grant pattern A,A,A,A,B,B,B,B,A...; waiting port's wait=1 on every lost cycle.
- B write 0x11223344 to 0x010 with byteen=4'b0101 over 0xAABBCCDD -> next A read of 0x010 returns 0xAA22CC44.
- Alternating A read / B read, one per cycle -> rvalid pulses alternate a,b,a,b each one cycle after its grant with correct data.
- Reset asserted in the cycle a B read is granted -> b_rvalid=0 next cycle; state IDLE; first grant after reset with both requesting goes to A.
- With SPRAM_ARB_STATS_EN: B held waiting 3 cycles behind an A burst -> b_stall_cnt=3, a_stall_cnt=0.
